// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, 1-cycle synchronous imem interface, stall-safe response hold and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to let the instruction after a taken branch execute as a MIPS delay slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] wb_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
);

    logic [31:0] pc_q, pc_d;
    logic        f2Valid_q, f2Valid_d;
    logic [31:0] f2Pc_q, f2Pc_d;
    logic        holdValid_q, holdValid_d;
    logic [31:0] holdInst_q, holdInst_d;
    logic [31:0] ifIdPc_q, ifIdPc_d;
    logic [31:0] ifIdPc4_q, ifIdPc4_d;
    logic [31:0] ifIdInst_q, ifIdInst_d;
    logic        ifIdValid_q, ifIdValid_d;

    logic        redirect;
    logic        slotValid;
    logic [31:0] f2Inst;

    assign imem_en     = ~stall & rst_n;
    assign imem_addr   = pc_q;
    assign if_id_pc    = ifIdPc_q;
    assign if_id_pc4   = ifIdPc4_q;
    assign if_id_inst  = ifIdInst_q;
    assign if_id_valid = ifIdValid_q;

    // The memory output is only valid for one cycle, so a response that arrives
    // during a stall is parked in hold_* and replayed on the first free edge.
    always_comb begin
        pc_d        = pc_q;
        f2Valid_d   = f2Valid_q;
        f2Pc_d      = f2Pc_q;
        holdValid_d = holdValid_q;
        holdInst_d  = holdInst_q;
        ifIdPc_d    = ifIdPc_q;
        ifIdPc4_d   = ifIdPc4_q;
        ifIdInst_d  = ifIdInst_q;
        ifIdValid_d = ifIdValid_q;
        slotValid   = 1'b0;
        redirect    = branch & ifIdValid_q & ~stall;
        f2Inst      = holdValid_q ? holdInst_q : imem_rdata;

        if (stall) begin
            if (f2Valid_q && !holdValid_q) begin
                holdValid_d = 1'b1;
                holdInst_d  = imem_rdata;
            end
        end else begin
            holdValid_d = 1'b0;
            f2Pc_d      = pc_q;
            ifIdPc_d    = f2Pc_q;
            ifIdPc4_d   = f2Pc_q + 32'd4;
            if (redirect) begin
                pc_d      = wb_pc;
                f2Valid_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                slotValid = f2Valid_q;
`else
                slotValid = 1'b0;
`endif
            end else begin
                pc_d      = pc_q + 32'd4;
                f2Valid_d = 1'b1;
                slotValid = f2Valid_q;
            end
            ifIdValid_d = slotValid;
            ifIdInst_d  = slotValid ? f2Inst : NOP_INST;
        end
    end

    // State register; reset discards any in-flight or held response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            f2Valid_q   <= 1'b0;
            f2Pc_q      <= RESET_PC;
            holdValid_q <= 1'b0;
            holdInst_q  <= 32'h0;
            ifIdPc_q    <= RESET_PC;
            ifIdPc4_q   <= RESET_PC + 32'd4;
            ifIdInst_q  <= NOP_INST;
            ifIdValid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            f2Valid_q   <= f2Valid_d;
            f2Pc_q      <= f2Pc_d;
            holdValid_q <= holdValid_d;
            holdInst_q  <= holdInst_d;
            ifIdPc_q    <= ifIdPc_d;
            ifIdPc4_q   <= ifIdPc4_d;
            ifIdInst_q  <= ifIdInst_d;
            ifIdValid_q <= ifIdValid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a slot-level stream model predicts every IF/ID load; a monitor compares.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'hDEAD_BEEF;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic [31:0] wbPc;
    logic        imemEn;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPc4;
    logic [31:0] ifIdInst;
    logic        ifIdValid;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch     (branch),
        .wb_pc      (wbPc),
        .imem_en    (imemEn),
        .imem_addr  (imemAddr),
        .imem_rdata (imemRdata),
        .if_id_pc   (ifIdPc),
        .if_id_pc4  (ifIdPc4),
        .if_id_inst (ifIdInst),
        .if_id_valid(ifIdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous memory: data only meaningful the cycle after an enabled read.
    always @(posedge clk) begin
        imemRdata <= imemEn ? memWord(imemAddr) : $urandom();
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        checkPc;
    } slot_t;

    slot_t       expQ[$];
    slot_t       cur;
    logic [31:0] nextPc;
    int          bubbles;
    logic        idValid;
    logic        idBranchable;
    int          assertCount = 0;
    int          failCount   = 0;
    logic        loadEdge;
    logic        rstEdge;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        nextPc       = RESET_PC;
        bubbles      = 1;
        idValid      = 1'b0;
        idBranchable = 1'b0;
    endtask

    // Drive one cycle's inputs (caller sits at a negedge) and predict the IF/ID slot of the coming edge.
    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt);
        logic brEff;
        brEff  = br && !(idValid && !idBranchable);
        stall  = st;
        branch = brEff;
        wbPc   = tgt;
        if (!st) begin
            if (brEff && idValid) begin
                expQ.push_back('{DS, nextPc, 1'b0});
                idValid      = DS;
                idBranchable = 1'b0;
                nextPc       = tgt;
                bubbles      = 1;
            end else if (bubbles > 0) begin
                expQ.push_back('{1'b0, 32'h0, 1'b0});
                bubbles--;
                idValid = 1'b0;
            end else begin
                expQ.push_back('{1'b1, nextPc, 1'b0});
                nextPc       = nextPc + 32'd4;
                idValid      = 1'b1;
                idBranchable = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkOutput();
        checkVal("imem_en", {31'h0, imemEn}, {31'h0, rst_n && !stall});
        checkVal("if_id_valid", {31'h0, ifIdValid}, {31'h0, cur.valid});
        checkVal("if_id_inst", ifIdInst, cur.valid ? memWord(cur.pc) : NOP);
        if (cur.valid || cur.checkPc) begin
            checkVal("if_id_pc", ifIdPc, cur.pc);
            checkVal("if_id_pc4", ifIdPc4, cur.pc + 32'd4);
        end
    endtask

    // Monitor: pop the next expected slot on every edge that loads IF/ID, otherwise expect it to hold.
    always @(posedge clk) begin
        loadEdge = rst_n && !stall;
        rstEdge  = !rst_n;
        #1;
        if (rstEdge) begin
            cur = '{1'b0, RESET_PC, 1'b1};
        end else if (loadEdge) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL scoreboard_empty: got no expected slot at %0t", $time);
            end else begin
                cur = expQ.pop_front();
            end
        end
        checkOutput();
    end

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        rst_n  = 1'b0;
        stall  = 1'b0;
        branch = 1'b0;
        wbPc   = 32'h0;
        cur    = '{1'b0, RESET_PC, 1'b1};
        resetModel();
        repeat (2) @(negedge clk);
        checkVal("reset_valid", {31'h0, ifIdValid}, 32'h0);
        checkVal("reset_inst", ifIdInst, NOP);
        checkVal("reset_pc", ifIdPc, RESET_PC);
        checkVal("reset_pc4", ifIdPc4, RESET_PC + 32'd4);
        checkVal("reset_imem_en", {31'h0, imemEn}, 32'h0);

        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0400);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b1, 1'b1, 32'h0000_0800);
        applyStimulus(1'b0, 1'b1, 32'h0000_0800);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);

        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkVal("async_rst_valid", {31'h0, ifIdValid}, 32'h0);
        checkVal("async_rst_inst", ifIdInst, NOP);
        checkVal("async_rst_pc_q", imemAddr, RESET_PC);
        checkVal("async_rst_imem_en", {31'h0, imemEn}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            tgt = r & 32'hFFFF_FFFC;
            if ((i % 37) == 5) tgt = 32'hFFFF_FFFC;
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt);
        end

        stall  = 1'b1;
        branch = 1'b0;
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
